ones_count: RTL and testbench
=============================

Name:
ones_count

Overview:
- Registered population counter: counts the 1 bits on a DATA_W-bit input word and presents the total on `count`.
- Used as a small utility block in datapaths that need a bit-weight or occupancy figure.
- Default configuration: 7-bit input, 3-bit count.
- Single clock domain; count is registered once.

Parameters:
- DATA_W, 7, width of input word `in` (legal range 1..64).
- CNT_W, 3, width of `count`; must equal ceil(log2(DATA_W+1)) so that the all-ones input is representable. Default 3 for DATA_W=7.

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst_n  input  1  asynchronous active-low reset; assertion clears state immediately, deassertion synchronous to clk by system.
- in  input  DATA_W  word whose 1 bits are counted; sampled every rising edge, no qualifier.
- count  output  CNT_W  registered number of 1 bits in `in` as sampled at the most recent rising edge.

Behaviour:
- Reset:
  - While rst_n=0, `count`=0 regardless of clk or `in`.
  - Effect is immediate (asynchronous), not at the next edge.
- Operation:
  - At each rising clk edge with rst_n=1, count <= popcount(in). Popcount is an unsigned sum of all DATA_W bits.
  - Latency: one cycle. A value on `in` set up before edge k appears on `count` just after edge k and holds until edge k+1.
  - No enable and no handshake; the counter recomputes every cycle.
  - A constant `in` yields a constant `count`.
- Arithmetic:
  - Combinational popcount is built as an adder tree of full/half adders. Each stage width grows by one bit as needed; the final sum is CNT_W bits.
  - No truncation or overflow is possible when CNT_W is legal. Maximum result is DATA_W (7 -> 3'b111).
- Output path: `count` comes directly from flops (no combinational path from `in` to `count`).
- Boundaries:
  - in = all zeros -> 0.
  - in = all ones -> DATA_W.
  - Single-bit input at any position (LSB, MSB, middle) -> 1; every bit position carries equal weight.
  - Back-to-back changes every cycle: each result corresponds exactly to its own sampled word, with no mixing between words.
- Reset mid-operation:
  - rst_n asserted between edges forces `count` to 0 at once.
  - After release, the first rising edge loads popcount of the current `in`.
- X handling: an X on any bit of `in` may propagate X to `count`; no masking is required.

Test Plan:
- Reset: hold rst_n=0 with in=7'b1111111 and clk toggling -> count=0 throughout. Release rst_n and apply one edge -> count=7.
- Directed vectors, one per cycle, each checked one cycle after apply:
  - 1010011 -> 4
  - 0111101 -> 5
  - 1111111 -> 7
  - 0000111 -> 3
  - 1000010 -> 2
  - 0010000 -> 1
  - 1011111 -> 6
  - 0110011 -> 4
- Extremes: in=0000000 -> 0. Walking single 1 across bits 0..6 -> count=1 every cycle. Walking single 0 in all-ones -> count=6 every cycle.
- Latency/no-comb-path: change `in` mid-cycle from 0000000 to 1111111 -> count stays 0 until the next rising edge, then becomes 7.
- Async reset mid-stream: while streaming the directed vectors, pulse rst_n low between edges -> count drops to 0 immediately without a clock edge. After release, the next edge shows popcount of the current `in`.
- Exhaustive: all 128 input values, one per cycle -> count equals reference popcount with 1-cycle lag. Repeat at DATA_W=15, CNT_W=4 for a 0..15 range check.

Source files
------------

// File: rtl/ones_count.sv
// ones_count: registered population counter.
// Counts the 1 bits of `in` through a binary adder tree built from half and
// full adders, then registers the total on `count` (one cycle of latency,
// no combinational path from `in` to `count`).
// CNT_W must equal ceil(log2(DATA_W+1)) so the all-ones word is representable.
module ones_count #(
    parameter int DATA_W = 7,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in,
    output logic [CNT_W-1:0]  count
);

    // The tree is a complete binary tree stored heap-style: node 0 is the
    // root, node n has children 2n+1 and 2n+2, leaves start at LEAVES-1.
    // Leaves beyond DATA_W are tied to zero, so every subtree sum is bounded
    // by DATA_W and always fits in CNT_W bits.
    localparam int LEVELS = $clog2(DATA_W);
    localparam int LEAVES = 1 << LEVELS;
    localparam int NODES  = 2 * LEAVES - 1;

    logic [CNT_W-1:0] node [NODES];

    // Leaves: one input bit each, zero-extended; padding leaves are zero.
    for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
        if (k < DATA_W) begin : g_bit
            assign node[LEAVES-1+k] = CNT_W'(in[k]);
        end else begin : g_pad
            assign node[LEAVES-1+k] = '0;
        end
    end

    // Internal nodes: a node of height H adds two children that are each
    // min(H, CNT_W) bits wide; the sum grows by one bit (the final carry)
    // until it reaches CNT_W, where the carry is provably always zero and
    // is simply not built.
    for (genvar n = 0; n < LEAVES - 1; n++) begin : g_node
        localparam int H  = LEVELS - ($clog2(n + 2) - 1);
        localparam int OW = (H < CNT_W) ? H : CNT_W;

        logic [CNT_W-1:0] sum;

        if (OW == 1) begin : g_ha
            // Bottom level: a single half adder per pair of input bits.
            assign sum[0] = node[2*n+1][0] ^ node[2*n+2][0];
            if (OW < CNT_W) begin : g_co
                assign sum[1] = node[2*n+1][0] & node[2*n+2][0];
            end
            if (OW + 1 < CNT_W) begin : g_zero
                assign sum[CNT_W-1:OW+1] = '0;
            end
        end else begin : g_rca
            // Ripple-carry adder: half adder at the LSB, full adders above.
            logic [OW-2:0] cy;

            for (genvar b = 0; b < OW; b++) begin : g_bit
                if (b == 0) begin : g_half
                    assign sum[0] = node[2*n+1][0] ^ node[2*n+2][0];
                    assign cy[0]  = node[2*n+1][0] & node[2*n+2][0];
                end else begin : g_full
                    assign sum[b] = node[2*n+1][b] ^ node[2*n+2][b] ^ cy[b-1];
                    if (b < OW - 1) begin : g_mid
                        assign cy[b] = (node[2*n+1][b] & node[2*n+2][b]) |
                                       (cy[b-1] & (node[2*n+1][b] ^ node[2*n+2][b]));
                    end else if (OW < CNT_W) begin : g_top
                        assign sum[OW] = (node[2*n+1][b] & node[2*n+2][b]) |
                                         (cy[b-1] & (node[2*n+1][b] ^ node[2*n+2][b]));
                    end
                end
            end

            if (OW + 1 < CNT_W) begin : g_zero
                assign sum[CNT_W-1:OW+1] = '0;
            end
        end

        assign node[n] = sum;
    end

    // Output register: capture the tree root every edge; async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values; a
            // blocking assignment here would create simulation races.
            count <= node[0];
        end
    end

endmodule

// File: tb/tb_ones_count.sv
// tb_ones_count: directed, table-driven and exhaustive checks of ones_count
// at the default 7-bit width plus a 15-bit / 4-bit instance.
module tb_ones_count;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  in7;
    logic [2:0]  count7;
    logic [14:0] in15;
    logic [3:0]  count15;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [6:0] in;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs [8];

    ones_count #(.DATA_W(7), .CNT_W(3)) u_dut7 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in7),
        .count (count7)
    );

    ones_count #(.DATA_W(15), .CNT_W(4)) u_dut15 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in15),
        .count (count15)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance past one rising edge and settle 2 time units after it.
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    function automatic int ref_pop(input logic [31:0] v);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(v[i]);
        return c;
    endfunction

    initial begin
        vecs[0] = '{7'b1010011, 3'd4};
        vecs[1] = '{7'b0111101, 3'd5};
        vecs[2] = '{7'b1111111, 3'd7};
        vecs[3] = '{7'b0000111, 3'd3};
        vecs[4] = '{7'b1000010, 3'd2};
        vecs[5] = '{7'b0010000, 3'd1};
        vecs[6] = '{7'b1011111, 3'd6};
        vecs[7] = '{7'b0110011, 3'd4};

        // Reset held with all-ones input and the clock running.
        rst_n = 1'b0;
        in7   = 7'h7f;
        in15  = 15'h7fff;
        #1;
        check("reset_initial", 32'(count7), 32'd0);
        check("reset_initial_w15", 32'(count15), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("reset_hold", 32'(count7), 32'd0);
        end

        // Release between edges, first edge loads the all-ones popcount.
        rst_n = 1'b1;
        cycle();
        check("reset_release", 32'(count7), 32'd7);
        check("reset_release_w15", 32'(count15), 32'd15);

        // Directed vectors, back to back.
        for (int i = 0; i < 8; i++) begin
            in7 = vecs[i].in;
            cycle();
            check($sformatf("vec%0d", i), 32'(count7), 32'(vecs[i].exp));
        end

        // Extremes: zero, walking one, walking zero.
        in7 = 7'b0000000;
        cycle();
        check("all_zero", 32'(count7), 32'd0);
        for (int k = 0; k < 7; k++) begin
            in7 = 7'(1 << k);
            cycle();
            check($sformatf("walk1_bit%0d", k), 32'(count7), 32'd1);
        end
        for (int k = 0; k < 7; k++) begin
            in7 = ~7'(1 << k);
            cycle();
            check($sformatf("walk0_bit%0d", k), 32'(count7), 32'd6);
        end

        // Latency: a mid-cycle input change must not reach count before the edge.
        in7 = 7'b0000000;
        cycle();
        check("lat_base", 32'(count7), 32'd0);
        in7 = 7'b1111111;
        #1;
        check("lat_no_comb_early", 32'(count7), 32'd0);
        #5;
        check("lat_no_comb_late", 32'(count7), 32'd0);
        @(posedge clk);
        #2;
        check("lat_after_edge", 32'(count7), 32'd7);

        // Async reset pulsed between edges while streaming vectors.
        for (int i = 0; i < 4; i++) begin
            in7 = vecs[i].in;
            cycle();
            check($sformatf("stream%0d", i), 32'(count7), 32'(vecs[i].exp));
        end
        rst_n = 1'b0;
        #1;
        check("async_assert", 32'(count7), 32'd0);
        #2;
        rst_n = 1'b1;
        in7   = vecs[4].in;
        #1;
        check("async_release_no_edge", 32'(count7), 32'd0);
        @(posedge clk);
        #2;
        check("async_first_edge", 32'(count7), 32'(vecs[4].exp));
        for (int i = 5; i < 8; i++) begin
            in7 = vecs[i].in;
            cycle();
            check($sformatf("stream%0d", i), 32'(count7), 32'(vecs[i].exp));
        end

        // Exhaustive at 7 bits.
        for (int v = 0; v < 128; v++) begin
            in7 = 7'(v);
            cycle();
            check($sformatf("exh7_%0d", v), 32'(count7), 32'(ref_pop(32'(v))));
        end

        // Exhaustive at 15 bits (count range 0..15).
        for (int v = 0; v < 32768; v++) begin
            in15 = 15'(v);
            cycle();
            check($sformatf("exh15_%0d", v), 32'(count15), 32'(ref_pop(32'(v))));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
